fp_reduce_ctrl: RTL

Sequential reduction controller that sits directly upstream and downstream of the floating-point adder. It accepts a stream of `float_t` elements terminated by a last flag. It drives the running total and each new element into the adder's operand handshake, then consumes the adder's sum handshake to update the running total. After the last element, it presents the final total and the element count on an output handshake.

---
 rtl/fp_reduce_ctrl_if.sv | 57 +++++
 rtl/fp_reduce_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fp_reduce_ctrl_if.sv
// Float element type and the handshake bundle around the reduction controller:
// element input, adder operand/sum channels and the result output.
package fp_reduce_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;
endpackage

interface fp_reduce_ctrl_if #(
    parameter int CountWidth = 16
);
    import fp_reduce_pkg::*;

    logic                  in_valid_i;
    logic                  in_ready_o;
    float_t                in_data_i;
    logic                  in_last_i;

    logic                  add_op_valid_o;
    logic                  add_op_ready_i;
    float_t                add_op_a_o;
    float_t                add_op_b_o;

    logic                  add_sum_valid_i;
    logic                  add_sum_ready_o;
    float_t                add_sum_data_i;

    logic                  out_valid_o;
    logic                  out_ready_i;
    float_t                out_data_o;
    logic [CountWidth-1:0] out_count_o;

    // master is the controller itself; slave is the surrounding system
    modport master (
        input  in_valid_i, in_data_i, in_last_i,
        output in_ready_o,
        output add_op_valid_o, add_op_a_o, add_op_b_o,
        input  add_op_ready_i,
        input  add_sum_valid_i, add_sum_data_i,
        output add_sum_ready_o,
        output out_valid_o, out_data_o, out_count_o,
        input  out_ready_i
    );

    modport slave (
        output in_valid_i, in_data_i, in_last_i,
        input  in_ready_o,
        input  add_op_valid_o, add_op_a_o, add_op_b_o,
        output add_op_ready_i,
        output add_sum_valid_i, add_sum_data_i,
        input  add_sum_ready_o,
        input  out_valid_o, out_data_o, out_count_o,
        output out_ready_i
    );
endinterface

// File: rtl/fp_reduce_ctrl.sv
// Sequential float reduction controller: feeds running total + next element to an
// external adder one pair at a time and reports the final total with element count.
module fp_reduce_ctrl
    import fp_reduce_pkg::*;
#(
    parameter int CountWidth = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fp_reduce_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ELEM,
        ST_ISSUE,
        ST_WAIT_SUM,
        ST_OUTPUT
    } state_e;

    localparam logic [CountWidth-1:0] CountMax = '1;
    localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

    state_e                state_q, state_d;
    float_t                acc_q, acc_d;
    float_t                elem_q, elem_d;
    logic                  last_q, last_d;
    logic [CountWidth-1:0] count_q, count_d;

    // Element count sticks at all-ones; the total keeps accumulating regardless
    function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] c);
        return (c == CountMax) ? c : c + CountOne;
    endfunction

    always_comb begin
        state_d             = state_q;
        acc_d               = acc_q;
        elem_d              = elem_q;
        last_d              = last_q;
        count_d             = count_q;
        bus.in_ready_o      = 1'b0;
        bus.add_op_valid_o  = 1'b0;
        bus.add_op_a_o      = '0;
        bus.add_op_b_o      = '0;
        bus.add_sum_ready_o = 1'b0;
        bus.out_valid_o     = 1'b0;
        bus.out_data_o      = '0;
        bus.out_count_o     = '0;

        unique case (state_q)
            ST_IDLE: begin
                bus.in_ready_o = 1'b1;
                // First element seeds the total directly, so a lone element never touches the adder
                if (bus.in_valid_i) begin
                    acc_d   = bus.in_data_i;
                    count_d = CountOne;
                    state_d = bus.in_last_i ? ST_OUTPUT : ST_WAIT_ELEM;
                end
            end
            ST_WAIT_ELEM: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) begin
                    elem_d  = bus.in_data_i;
                    last_d  = bus.in_last_i;
                    count_d = sat_inc(count_q);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.add_op_valid_o = 1'b1;
                bus.add_op_a_o     = acc_q;
                bus.add_op_b_o     = elem_q;
                if (bus.add_op_ready_i) begin
                    state_d = ST_WAIT_SUM;
                end
            end
            ST_WAIT_SUM: begin
                bus.add_sum_ready_o = 1'b1;
                if (bus.add_sum_valid_i) begin
                    acc_d   = bus.add_sum_data_i;
                    state_d = last_q ? ST_OUTPUT : ST_WAIT_ELEM;
                end
            end
            ST_OUTPUT: begin
                bus.out_valid_o = 1'b1;
                bus.out_data_o  = acc_q;
                bus.out_count_o = count_q;
                if (bus.out_ready_i) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            elem_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            elem_q  <= elem_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // A stalled operand pair or result must not change until it is taken
    op_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.add_op_valid_o && !bus.add_op_ready_i) |=>
        (bus.add_op_valid_o && $stable(bus.add_op_a_o) && $stable(bus.add_op_b_o)));

    out_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.out_valid_o && !bus.out_ready_i) |=>
        (bus.out_valid_o && $stable(bus.out_data_o) && $stable(bus.out_count_o)));

endmodule
